// File: rtl/eight_dot_product_multiply_with_control_if.sv
// Beat-level bus between the vector wrapper and the 8-lane dot-product engine.
interface eight_dot_product_multiply_with_control_if #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8
);
  logic [31:0]                          total;
  logic [element_width*no_of_units-1:0] first_row_input;
  logic [element_width*no_of_units-1:0] second_row_input;
  logic                                 outsider_read_now;
  logic [31:0]                          result;
  logic                                 finish;

  modport master (
    output total, first_row_input, second_row_input, outsider_read_now,
    input  result, finish
  );

  modport slave (
    input  total, first_row_input, second_row_input, outsider_read_now,
    output result, finish
  );
endinterface

// File: rtl/eight_dot_product_multiply_with_control.sv
// 8-lane signed dot-product engine: multiply, 3-level adder tree, 64-bit accumulator, sticky finish.
// Define DOTP_SATURATE_EN to clamp result to the signed 32-bit range instead of wrapping.
module eight_dot_product_multiply_with_control #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8
) (
  input logic clk,
  input logic reset,
  eight_dot_product_multiply_with_control_if.slave bus
);
  localparam int PW = 2 * element_width;

  typedef enum logic [0:0] {ST_RUN, ST_DONE} state_t;

  state_t r_state, w_state_next;

  logic [31:0]          r_total_q;
  logic [29:0]          r_beats_accepted;
  logic [32:0]          w_total_plus;
  logic [29:0]          w_beats_needed;
  logic [2:0]           w_rem;
  logic                 w_accept;
  logic                 w_last_beat;

  logic signed [PW-1:0] w_prod [no_of_units];
  logic signed [PW-1:0] r_prod [no_of_units];
  logic signed [PW-1:0] r_s2   [4];
  logic signed [PW-1:0] r_s3   [2];
  logic signed [PW-1:0] r_s4;
  logic signed [PW-1:0] r_acc;
  logic                 r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
  logic                 r_s1_last,  r_s2_last,  r_s3_last,  r_s4_last;
  logic [31:0]          w_result;

  assign w_total_plus   = {1'b0, r_total_q} + 33'd7;
  assign w_beats_needed = w_total_plus[32:3];
  assign w_rem          = r_total_q[2:0];
  assign w_accept       = (r_state == ST_RUN) && bus.outsider_read_now &&
                          (r_beats_accepted < w_beats_needed);
  assign w_last_beat    = (r_beats_accepted == (w_beats_needed - 30'd1));

  // Lanes past the remainder on the final beat contribute nothing.
  genvar gi;
  generate
    for (gi = 0; gi < no_of_units; gi++) begin : g_lane
      logic signed [element_width-1:0] w_a, w_b;
      logic                            w_lane_en;
      assign w_a       = bus.first_row_input[gi*element_width +: element_width];
      assign w_b       = bus.second_row_input[gi*element_width +: element_width];
      assign w_lane_en = (w_rem == 3'd0) || !w_last_beat || (3'(gi) < w_rem);
      assign w_prod[gi] = w_lane_en ? (PW'(w_a) * PW'(w_b)) : '0;

      always_ff @(posedge clk) begin
        if (reset) r_prod[gi] <= '0;
        else if (w_accept) r_prod[gi] <= w_prod[gi];
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_s2
      always_ff @(posedge clk) begin
        if (reset) r_s2[gi] <= '0;
        else r_s2[gi] <= r_prod[2*gi] + r_prod[2*gi+1];
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_s3
      always_ff @(posedge clk) begin
        if (reset) r_s3[gi] <= '0;
        else r_s3[gi] <= r_s2[2*gi] + r_s2[2*gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_total_q        <= bus.total;
      r_beats_accepted <= '0;
      r_s1_valid <= 1'b0; r_s2_valid <= 1'b0; r_s3_valid <= 1'b0; r_s4_valid <= 1'b0;
      r_s1_last  <= 1'b0; r_s2_last  <= 1'b0; r_s3_last  <= 1'b0; r_s4_last  <= 1'b0;
      r_s4  <= '0;
      r_acc <= '0;
    end else begin
      if (w_accept) r_beats_accepted <= r_beats_accepted + 30'd1;
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && w_last_beat;
      r_s2_valid <= r_s1_valid; r_s2_last <= r_s1_last;
      r_s3_valid <= r_s2_valid; r_s3_last <= r_s2_last;
      r_s4_valid <= r_s3_valid; r_s4_last <= r_s3_last;
      r_s4 <= r_s3[0] + r_s3[1];
      if (r_s4_valid) r_acc <= r_acc + r_s4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // A zero-length product is complete as soon as reset releases.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if ((w_beats_needed == 30'd0) || (r_s4_valid && r_s4_last))
                 w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_RUN;
    endcase
  end

`ifdef DOTP_SATURATE_EN
  localparam logic signed [PW-1:0] SAT_MAX = PW'(64'sd2147483647);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-64'sd2147483648);
  always_comb begin
    w_result = r_acc[31:0];
    if (r_acc > SAT_MAX)      w_result = 32'h7FFFFFFF;
    else if (r_acc < SAT_MIN) w_result = 32'h80000000;
  end
`else
  assign w_result = r_acc[31:0];
`endif

  assign bus.result = w_result;
  assign bus.finish = (r_state == ST_DONE);
endmodule

// File: tb/tb_eight_dot_product_multiply_with_control.sv
// Directed self-checking bench for the 8-lane dot-product engine.
module tb_eight_dot_product_multiply_with_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  eight_dot_product_multiply_with_control_if bus ();

  eight_dot_product_multiply_with_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] fill(input logic [31:0] v);
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[32*k +: 32] = v;
    return f;
  endfunction

  task automatic do_reset(input logic [31:0] t);
    reset = 1'b1;
    bus.total = t;
    bus.outsider_read_now = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] a, input logic [255:0] b);
    bus.first_row_input  = a;
    bus.second_row_input = b;
    bus.outsider_read_now = 1'b1;
    @(posedge clk); #1;
    bus.outsider_read_now = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.total = 32'd8;
    bus.outsider_read_now = 1'b1;
    bus.first_row_input = fill(32'd1);
    bus.second_row_input = fill(32'd1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== 32'd0) begin
      errors++; $display("FAIL reset_result got %h exp 00000000", bus.result);
    end
    checks++;
    if (bus.finish !== 1'b0) begin
      errors++; $display("FAIL reset_finish got %b exp 0", bus.finish);
    end
    bus.outsider_read_now = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_beat;
    logic [255:0] a;
    do_reset(32'd8);
    for (int k = 0; k < 8; k++) a[32*k +: 32] = 32'(k + 1);
    send_beat(a, fill(32'd1));
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.finish !== 1'b0) begin
        errors++; $display("FAIL t1_finish_early cyc %0d got %b exp 0", c, bus.finish);
      end
      if (c < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.finish !== 1'b1) begin
      errors++; $display("FAIL t1_finish got %b exp 1", bus.finish);
    end
    checks++;
    if (bus.result !== 32'd36) begin
      errors++; $display("FAIL t1_result got %0d exp 36", bus.result);
    end
    $display("test_single_beat result=%0d finish=%b", bus.result, bus.finish);
  endtask

  task automatic test_gap;
    do_reset(32'd16);
    send_beat(fill(32'd2), fill(32'd2));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.finish !== 1'b0) begin
      errors++; $display("FAIL t2_finish_mid got %b exp 0", bus.finish);
    end
    send_beat(fill(32'd2), fill(32'd2));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.finish !== 1'b0) begin
      errors++; $display("FAIL t2_finish_early got %b exp 0", bus.finish);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.finish !== 1'b1) begin
      errors++; $display("FAIL t2_finish got %b exp 1", bus.finish);
    end
    checks++;
    if (bus.result !== 32'd64) begin
      errors++; $display("FAIL t2_result got %0d exp 64", bus.result);
    end
    $display("test_gap result=%0d finish=%b", bus.result, bus.finish);
  endtask

  task automatic test_mask;
    do_reset(32'd5);
    send_beat(fill(32'd3), fill(32'd3));
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.finish !== 1'b1) begin
      errors++; $display("FAIL t3_finish got %b exp 1", bus.finish);
    end
    checks++;
    if (bus.result !== 32'd45) begin
      errors++; $display("FAIL t3_result got %0d exp 45", bus.result);
    end
    $display("test_mask result=%0d finish=%b", bus.result, bus.finish);
  endtask

  task automatic test_negative_extra;
    do_reset(32'd8);
    send_beat(fill(-32'sd4), fill(32'd5));
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== 32'hFFFFFF60) begin
      errors++; $display("FAIL t4_result got %h exp ffffff60", bus.result);
    end
    for (int s = 0; s < 4; s++) send_beat(fill(32'd7), fill(32'd7));
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== 32'hFFFFFF60) begin
      errors++; $display("FAIL t4_result_after_extra got %h exp ffffff60", bus.result);
    end
    checks++;
    if (bus.finish !== 1'b1) begin
      errors++; $display("FAIL t4_finish_sticky got %b exp 1", bus.finish);
    end
    $display("test_negative_extra result=%h finish=%b", bus.result, bus.finish);
  endtask

  task automatic test_overflow;
    logic [31:0] exp_r;
`ifdef DOTP_SATURATE_EN
    exp_r = 32'h7FFFFFFF;
`else
    exp_r = 32'hFFFFFFF0;
`endif
    do_reset(32'd8);
    send_beat(fill(32'h7FFFFFFF), fill(32'd2));
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== exp_r) begin
      errors++; $display("FAIL t5_result got %h exp %h", bus.result, exp_r);
    end
    $display("test_overflow result=%h", bus.result);
  endtask

  task automatic test_back_to_back;
    do_reset(32'd24);
    send_beat(fill(32'd1), fill(32'd1));
    send_beat(fill(32'd2), fill(32'd3));
    send_beat(fill(-32'sd1), fill(32'd1));
    send_beat(fill(32'd9), fill(32'd9));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.finish !== 1'b1) begin
      errors++; $display("FAIL b2b_finish got %b exp 1", bus.finish);
    end
    checks++;
    if (bus.result !== 32'd48) begin
      errors++; $display("FAIL b2b_result got %0d exp 48", bus.result);
    end
    $display("test_back_to_back result=%0d finish=%b", bus.result, bus.finish);
  endtask

  task automatic test_reset_mid;
    do_reset(32'd16);
    send_beat(fill(32'd5), fill(32'd5));
    @(posedge clk); #1;
    reset = 1'b1;
    bus.total = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (bus.result !== 32'd0) begin
      errors++; $display("FAIL t6_abort_result got %h exp 00000000", bus.result);
    end
    checks++;
    if (bus.finish !== 1'b0) begin
      errors++; $display("FAIL t6_abort_finish got %b exp 0", bus.finish);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.finish !== 1'b1) begin
      errors++; $display("FAIL t6_zero_finish got %b exp 1", bus.finish);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== 32'd0) begin
      errors++; $display("FAIL t6_zero_result got %h exp 00000000", bus.result);
    end
    $display("test_reset_mid result=%0d finish=%b", bus.result, bus.finish);
  endtask

  initial begin
    bus.total = 32'd0;
    bus.first_row_input = '0;
    bus.second_row_input = '0;
    bus.outsider_read_now = 1'b0;
    test_reset();
    test_single_beat();
    test_gap();
    test_mask();
    test_negative_extra();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
